full_st1_data_mem: RTL and testbench
====================================

FULL_ST1_DATA_MEM -- requirements
Module: full_st1_data_mem

Interface
REQ-001 Parameter DATA_W, default 32, data word width; matches the stage_1 float word.
REQ-002 Parameter ADDR_W, default 7, word address width; upper 3 bits are the slot (depth) index, lower 4 bits are the word (width) index.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_valid  input  1  write strobe, driven from the upstream data_valid.
REQ-006 wr_addr  input  ADDR_W  write address, driven from the upstream data_write_addr.
REQ-007 wr_data  input  DATA_W  write data, driven from the upstream data_value.
REQ-008 wr_last  input  1  qualifies wr_valid as the last word of a slot burst.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_addr  input  ADDR_W  read address, driven from the upstream data_read_addr.
REQ-011 rd_release  input  1  frees the slot addressed by rd_addr[6:4], driven from the upstream read_finish.
REQ-012 clear_err  input  1  clears the sticky error flags.
REQ-013 rd_data  output  DATA_W  read data.
REQ-014 rd_valid  output  1  rd_data holds a new word this cycle.
REQ-015 slot_full  output  8  per-slot filled flags.
REQ-016 occupancy  output  4  number of set bits in slot_full, range 0..8.
REQ-017 overrun  output  1  sticky flag: a write targeted a slot that was already full.
REQ-018 underrun  output  1  sticky flag: a read targeted an empty slot.

Function
REQ-019 Storage SHALL be a 2^ADDR_W x DATA_W array; its contents SHALL NOT be reset.
REQ-020 When wr_valid=1, the block SHALL write mem[wr_addr] <= wr_data at the clock edge.
REQ-021 Read latency SHALL be exactly 2 cycles: an rd_en in cycle N SHALL produce rd_valid=1 and the data in cycle N+2.
REQ-022 Read pipeline stage 1 (cycle N) SHALL capture mem[rd_addr] into a register; stage 2 SHALL move that register to rd_data.
REQ-023 Read/write collision, same cycle: when wr_valid=1, rd_en=1 and wr_addr==rd_addr in cycle N, stage 1 SHALL capture wr_data (write-first).
REQ-024 Read/write collision, next cycle: a write to the same address in cycle N+1 SHALL NOT affect the data returned for a read issued in cycle N.
REQ-025 rd_data SHALL hold its previous value in any cycle where rd_valid=0.
REQ-026 Back-to-back rd_en SHALL give one rd_valid per request, with no bubbles.
REQ-027 slot_full[s] SHALL set on wr_valid & wr_last & (wr_addr[6:4]==s).
REQ-028 slot_full[s] SHALL clear on rd_release & (rd_addr[6:4]==s).
REQ-029 If the set and clear conditions of REQ-027 and REQ-028 hit the same slot in the same cycle, set SHALL win.
REQ-030 overrun SHALL set when wr_valid=1 and slot_full[wr_addr[6:4]]=1, unless that slot is being released in the same cycle; the write SHALL still be performed.
REQ-031 underrun SHALL set when rd_en=1 and slot_full[rd_addr[6:4]]=0; the read SHALL still be performed.
REQ-032 clear_err=1 SHALL clear overrun and underrun; a new error detected in the same cycle SHALL take priority, leaving the flag at 1.
REQ-033 occupancy SHALL be the combinational popcount of the registered slot_full, so it reflects slot_full with zero additional latency.
REQ-034 Addresses SHALL wrap naturally at 2^ADDR_W; the block SHALL perform no range checking.

Reset
REQ-035 Reset SHALL drive rd_data=0, rd_valid=0, slot_full=0, occupancy=0, overrun=0, underrun=0, and clear the read pipeline.
REQ-036 A read in flight when reset asserts SHALL be discarded: no rd_valid pulse SHALL follow the reset.
REQ-037 Writes presented while reset=1 SHALL be ignored.

Verification
REQ-038 Basic write/read: write 16 words 0x100..0x10F to addresses 0x00..0x0F with wr_last on the last word, then read 0x00..0x0F back-to-back -> 16 consecutive rd_valid pulses starting 2 cycles after the first rd_en, data matching; slot_full=8'h01, occupancy=1.
REQ-039 Same-cycle collision: memory holds 0xAAAA at 0x23; write 0x5555 to 0x23 together with rd_en at 0x23 -> rd_data=0x5555 two cycles later.
REQ-040 Next-cycle write: memory holds 0xAAAA at 0x23; read 0x23, then write 0x5555 to 0x23 in the following cycle -> rd_data=0xAAAA.
REQ-041 Overrun and clear: fill slot 2; write to 0x20 again -> overrun=1 and the data is written; assert clear_err alone -> overrun=0; assert clear_err together with a new overrun -> overrun stays 1.
REQ-042 Release conflict: slot 5 is full; rd_release with rd_addr=0x50 in the same cycle as a wr_last write to 0x5F -> slot_full[5]=1 and no overrun.
REQ-043 Reset mid-read: issue rd_en, assert reset in the next cycle -> rd_valid stays 0, all flags return to 0, and a subsequent read of an empty slot -> underrun=1.

Source files
------------

// File: rtl/full_st1_data_mem.sv
// Stage-1 float data buffer: 8 slots of 16 words with a 2-cycle write-first read
// pipeline, per-slot full tracking and sticky overrun/underrun flags.
module full_st1_data_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_release,
    input  logic              clear_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [7:0]        slot_full,
    output logic [3:0]        occupancy,
    output logic              overrun,
    output logic              underrun
);

    localparam int SLOT_W    = 3;
    localparam int NUM_SLOTS = 1 << SLOT_W;
    localparam int DEPTH     = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [SLOT_W-1:0] wr_slot;
    logic [SLOT_W-1:0] rd_slot;
    assign wr_slot = wr_addr[ADDR_W-1 -: SLOT_W];
    assign rd_slot = rd_addr[ADDR_W-1 -: SLOT_W];

    // Storage is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && wr_valid) begin
            mem[wr_addr] <= wr_data;
        end
    end

    logic              rd_bypass;
    logic [DATA_W-1:0] rd_stage_reg;
    logic              rd_stage_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;

    assign rd_bypass = wr_valid & (wr_addr == rd_addr);

    // Stage 1: forward the in-flight write so same-cycle collisions read new data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_stage_reg       <= '0;
            rd_stage_valid_reg <= 1'b0;
        end else begin
            rd_stage_valid_reg <= rd_en;
            if (rd_en) begin
                rd_stage_reg <= rd_bypass ? wr_data : mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_stage_valid_reg;
            if (rd_stage_valid_reg) begin
                rd_data_reg <= rd_stage_reg;
            end
        end
    end

    logic [NUM_SLOTS-1:0] slot_set;
    logic [NUM_SLOTS-1:0] slot_clr;
    logic [NUM_SLOTS-1:0] slot_full_reg;
    logic [NUM_SLOTS-1:0] slot_full_next;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign slot_set[gi]       = wr_valid & wr_last & (wr_slot == SLOT_W'(gi));
            assign slot_clr[gi]       = rd_release & (rd_slot == SLOT_W'(gi));
            // A burst completing in the same cycle as a release keeps the slot full.
            assign slot_full_next[gi] = slot_set[gi] | (slot_full_reg[gi] & ~slot_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_full_reg <= '0;
        end else begin
            slot_full_reg <= slot_full_next;
        end
    end

    logic overrun_hit;
    logic underrun_hit;
    logic overrun_reg;
    logic underrun_reg;
    logic overrun_next;
    logic underrun_next;

    assign overrun_hit   = wr_valid & slot_full_reg[wr_slot] & ~slot_clr[wr_slot];
    assign underrun_hit  = rd_en & ~slot_full_reg[rd_slot];
    assign overrun_next  = overrun_hit  | (overrun_reg  & ~clear_err);
    assign underrun_next = underrun_hit | (underrun_reg & ~clear_err);

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_reg  <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            overrun_reg  <= overrun_next;
            underrun_reg <= underrun_next;
        end
    end

    logic [3:0] occupancy_sum;
    always_comb begin
        occupancy_sum = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            occupancy_sum = occupancy_sum + {3'b000, slot_full_reg[i]};
        end
    end

    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;
    assign slot_full = slot_full_reg;
    assign occupancy = occupancy_sum;
    assign overrun   = overrun_reg;
    assign underrun  = underrun_reg;

endmodule

// File: tb/tb_full_st1_data_mem.sv
// Directed and random checks of full_st1_data_mem against a queue-based
// behavioural model of memory contents, slot flags and read returns.
module tb_full_st1_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_last;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic        rd_release;
    logic        clear_err;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [7:0]  slot_full;
    logic [3:0]  occupancy;
    logic        overrun;
    logic        underrun;

    full_st1_data_mem #(.DATA_W(32), .ADDR_W(7)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release), .clear_err(clear_err),
        .rd_data(rd_data), .rd_valid(rd_valid), .slot_full(slot_full),
        .occupancy(occupancy), .overrun(overrun), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_req_t;

    logic [31:0] m_mem [128];
    rd_req_t     pipe [$];
    logic [7:0]  m_full;
    logic        m_over, m_under, m_rd_valid;
    logic [31:0] m_rd_data;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_addr = 0; wr_data = 0; wr_last = 0;
        rd_en = 0; rd_addr = 0; rd_release = 0; clear_err = 0;
    endtask

    // One clock: the DUT samples the current inputs, the model applies the same
    // inputs, then every output is compared one time unit after the edge.
    task automatic tick();
        logic [2:0] ws, rs;
        @(posedge clk);
        cyc++;
        ws = wr_addr[6:4];
        rs = rd_addr[6:4];
        if (reset) begin
            m_full = 0; m_over = 0; m_under = 0;
            m_rd_valid = 0; m_rd_data = 0;
            pipe.delete();
        end else begin
            m_over  = (wr_valid && m_full[ws] && !(rd_release && rs == ws)) || (m_over && !clear_err);
            m_under = (rd_en && !m_full[rs]) || (m_under && !clear_err);
            if (rd_en)
                pipe.push_back('{data: (wr_valid && wr_addr == rd_addr) ? wr_data : m_mem[rd_addr],
                                 due: cyc + 1});
            if (rd_release) m_full[rs] = 1'b0;
            if (wr_valid && wr_last) m_full[ws] = 1'b1;
            if (wr_valid) m_mem[wr_addr] = wr_data;
            m_rd_valid = 0;
            if (pipe.size() > 0 && pipe[0].due == cyc) begin
                m_rd_valid = 1;
                m_rd_data  = pipe[0].data;
                void'(pipe.pop_front());
            end
        end
        #1;
        check("rd_valid",  {31'b0, rd_valid},  {31'b0, m_rd_valid});
        check("rd_data",   rd_data,            m_rd_data);
        check("slot_full", {24'b0, slot_full}, {24'b0, m_full});
        check("occupancy", {28'b0, occupancy}, $countones(m_full));
        check("overrun",   {31'b0, overrun},   {31'b0, m_over});
        check("underrun",  {31'b0, underrun},  {31'b0, m_under});
    endtask

    task automatic write(input logic [6:0] a, input logic [31:0] d, input logic last);
        idle_inputs();
        wr_valid = 1; wr_addr = a; wr_data = d; wr_last = last;
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick();
        tick();
        check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset_slot_full", {24'b0, slot_full}, 32'd0);
        reset = 0;

        // Give every address a known value without filling any slot.
        for (int i = 0; i < 128; i++) write(7'(i), $urandom, 1'b0);

        // Basic burst into slot 0 then 16 back-to-back reads.
        for (int i = 0; i < 16; i++) write(7'(i), 32'h100 + i, i == 15);
        for (int i = 0; i < 16; i++) begin
            idle_inputs(); rd_en = 1; rd_addr = 7'(i);
            tick();
            if (i >= 1) check("burst_data", rd_data, 32'h100 + i - 1);
        end
        idle_inputs();
        tick();
        check("burst_last", rd_data, 32'h10F);
        check("burst_full", {24'b0, slot_full}, 32'h01);
        check("burst_occ", {28'b0, occupancy}, 32'd1);

        // Same-cycle collision returns the new data.
        write(7'h23, 32'hAAAA, 1'b0);
        idle_inputs(); wr_valid = 1; wr_addr = 7'h23; wr_data = 32'h5555; rd_en = 1; rd_addr = 7'h23;
        tick();
        idle_inputs();
        tick();
        check("coll_same", rd_data, 32'h5555);

        // Write in the following cycle does not disturb the issued read.
        write(7'h23, 32'hAAAA, 1'b0);
        idle_inputs(); rd_en = 1; rd_addr = 7'h23;
        tick();
        write(7'h23, 32'h5555, 1'b0);
        check("coll_next", rd_data, 32'hAAAA);
        check("coll_next_v", {31'b0, rd_valid}, 32'd1);

        // Overrun, clear, and clear colliding with a new overrun.
        idle_inputs(); clear_err = 1;
        tick();
        for (int i = 0; i < 16; i++) write(7'h20 + 7'(i), 32'h200 + i, i == 15);
        write(7'h20, 32'hBEEF, 1'b0);
        check("ovr_set", {31'b0, overrun}, 32'd1);
        idle_inputs(); clear_err = 1;
        tick();
        check("ovr_clr", {31'b0, overrun}, 32'd0);
        idle_inputs(); clear_err = 1; wr_valid = 1; wr_addr = 7'h21; wr_data = 32'hCAFE;
        tick();
        check("ovr_prio", {31'b0, overrun}, 32'd1);
        idle_inputs(); rd_en = 1; rd_addr = 7'h20;
        tick();
        idle_inputs();
        tick();
        check("ovr_written", rd_data, 32'hBEEF);

        // Release of slot 5 coinciding with its final burst write.
        idle_inputs(); clear_err = 1;
        tick();
        for (int i = 0; i < 16; i++) write(7'h50 + 7'(i), 32'h500 + i, i == 15);
        idle_inputs(); rd_release = 1; rd_addr = 7'h50;
        wr_valid = 1; wr_addr = 7'h5F; wr_data = 32'h5F5F; wr_last = 1;
        tick();
        check("rel_full5", {31'b0, slot_full[5]}, 32'd1);
        check("rel_no_ovr", {31'b0, overrun}, 32'd0);

        // Reset with a read in flight; a write during reset must be ignored.
        idle_inputs(); rd_en = 1; rd_addr = 7'h10;
        tick();
        idle_inputs(); reset = 1; wr_valid = 1; wr_addr = 7'h7F; wr_data = 32'hDEAD; wr_last = 1;
        tick();
        reset = 0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_valid", {31'b0, rd_valid}, 32'd0);
        end
        check("rst_flags", {22'b0, slot_full, overrun, underrun}, 32'd0);
        idle_inputs(); rd_en = 1; rd_addr = 7'h7F;
        tick();
        check("rst_underrun", {31'b0, underrun}, 32'd1);
        idle_inputs();
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            wr_valid   = 1'($urandom_range(0, 1));
            wr_addr    = 7'($urandom_range(0, 127));
            wr_data    = $urandom;
            wr_last    = ($urandom_range(0, 7) == 0);
            rd_en      = 1'($urandom_range(0, 1));
            rd_addr    = 7'($urandom_range(0, 127));
            rd_release = ($urandom_range(0, 7) == 0);
            clear_err  = ($urandom_range(0, 15) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 0;
        idle_inputs();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
